// File: rtl/f_pkg.sv
// Shared FP32 field widths, constants and converter state encoding.
// Imported by the int-to-float converter and the adder's normalization path.
package f_pkg;

   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   // Exponent of a magnitude whose leading one sits in bit 31.
   localparam logic [EXP_W-1:0] EXP_INT_TOP = EXP_W'(EXP_BIAS + 31);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/f_itof_if.sv
// Producer/consumer bundle of the integer-to-FP32 converter.
// Both sides: a word moves on a rising edge where valid & ready; valid holds
// its payload steady until then and never waits on ready.
interface f_itof_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_inexact;

   modport master (
      output in_valid, in_data, in_signed, out_ready,
      input  in_ready, out_valid, out_data, out_inexact
   );

   modport slave (
      input  in_valid, in_data, in_signed, out_ready,
      output in_ready, out_valid, out_data, out_inexact
   );

endinterface

// File: rtl/f_round_rne.sv
// Round-to-nearest-even packer: normalized magnitude (implicit one dropped)
// plus exponent and sign to a packed FP32 word and an inexact flag.
module f_round_rne
   import f_pkg::*;
(
   input  logic [EXP_W-1:0] exp,
   input  logic [30:0]      mag,
   input  logic             sign,
   output logic [31:0]      fp,
   output logic             inexact
);

   logic [MAN_W-1:0]       man;
   logic                   lsb;
   logic                   guard;
   logic                   sticky;
   logic                   up;
   logic [EXP_W+MAN_W-1:0] body;

   assign man    = mag[30:8];
   assign lsb    = mag[8];
   assign guard  = mag[7];
   assign sticky = |mag[6:0];
   assign up     = guard & (sticky | lsb);

   // A mantissa carry ripples into the exponent field by design.
   assign body    = {exp, man} + (EXP_W + MAN_W)'(up);
   assign fp      = {sign, body};
   assign inexact = guard | sticky;

endmodule

// File: rtl/f_itof.sv
// Multi-cycle 32-bit integer (signed or unsigned) to FP32 converter.
// Normalizes with coarse/single-bit shifts, then rounds to nearest even.
module f_itof
   import f_pkg::*;
#(
   parameter int COARSE_SHIFT = 8
) (
   input  logic     clk,
   input  logic     rst,
   f_itof_if.slave  bus,
   output state_e   dbg_state
);

   state_e           state;
   state_e           state_next;
   logic [31:0]      mag_q;
   logic [EXP_W-1:0] exp_q;
   logic             sign_q;

   logic             in_sign;
   logic [31:0]      in_mag;
   logic             coarse_zero;
   logic [31:0]      rne_fp;
   logic             rne_inexact;

   assign in_sign     = bus.in_signed & bus.in_data[31];
   assign in_mag      = in_sign ? (~bus.in_data + 32'd1) : bus.in_data;
   assign coarse_zero = (mag_q[31 -: COARSE_SHIFT] == '0);

   assign bus.in_ready = (state == IDLE);
   assign dbg_state    = state;

   f_round_rne u_round (
      .exp     (exp_q),
      .mag     (mag_q[30:0]),
      .sign    (sign_q),
      .fp      (rne_fp),
      .inexact (rne_inexact)
   );

   // A zero operand skips NORM (it would never find a leading one) and lets
   // ROUND emit +0, giving the one-edge latency for zero.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = (in_mag == '0) ? ROUND : NORM;
         NORM:    if (mag_q[31]) state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         mag_q           <= '0;
         exp_q           <= '0;
         sign_q          <= 1'b0;
         bus.out_valid   <= 1'b0;
         bus.out_data    <= FP_ZERO;
         bus.out_inexact <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign_q <= in_sign;
                  mag_q  <= in_mag;
                  exp_q  <= EXP_INT_TOP;
               end
            end
            NORM: begin
               if (!mag_q[31]) begin
                  if (coarse_zero) begin
                     mag_q <= mag_q << COARSE_SHIFT;
                     exp_q <= exp_q - EXP_W'(COARSE_SHIFT);
                  end else begin
                     mag_q <= mag_q << 1;
                     exp_q <= exp_q - EXP_W'(1);
                  end
               end
            end
            ROUND: begin
               bus.out_data    <= mag_q[31] ? rne_fp : FP_ZERO;
               bus.out_inexact <= mag_q[31] & rne_inexact;
               bus.out_valid   <= 1'b1;
            end
            DONE: begin
               if (bus.out_ready) bus.out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
